bus_rom_line_buffer: RTL

- Read line buffer between the Eco32 bus slave decoder (upstream) and the flash ROM bus interface (downstream).
- Holds one aligned line of 2^LINE_WORDS_LOG2 32-bit words with per-word valid bits.
- Answers read hits with zero wait states. On a miss, fills the line with sequential word reads and forwards the requested word as soon as it arrives. Writes pass straight through.

---
 rtl/bus_rom_line_buffer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/bus_rom_line_buffer.sv
// Single-line read buffer in front of the flash ROM bus.
// Hits return with no wait; misses fill the whole line and forward early.
module bus_rom_line_buffer #(
  parameter int ADDRESS_WIDTH = 21,
  parameter int LINE_WORDS_LOG2 = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     invalidate,
  input  logic                     busEnable,
  input  logic                     busWrite,
  input  logic [1:0]               busAccessSize,
  input  logic [ADDRESS_WIDTH-1:0] busAddress,
  input  logic [31:0]              busWriteData,
  output logic [31:0]              busReadData,
  output logic                     busWait,
  output logic                     romBusEnable,
  output logic                     romBusWrite,
  output logic [1:0]               romBusAccessSize,
  output logic [ADDRESS_WIDTH-1:0] romBusAddress,
  output logic [31:0]              romBusWriteData,
  input  logic [31:0]              romBusReadData,
  input  logic                     romBusWait
);

  localparam int Words = 1 << LINE_WORDS_LOG2;
  localparam int TagWidth = ADDRESS_WIDTH - LINE_WORDS_LOG2 - 2;
  localparam logic [LINE_WORDS_LOG2-1:0] LastIndex = '1;

  typedef enum logic [1:0] {
    Idle,
    Fill,
    Write
  } state_t;

  state_t state;
  state_t stateNext;

  logic [TagWidth-1:0]        lineTag;
  logic [Words-1:0]           wordValid;
  logic [31:0]                lineData [Words];
  logic [LINE_WORDS_LOG2-1:0] fillIndex;
  logic                       invalPending;

  logic [TagWidth-1:0]        reqTag;
  logic [LINE_WORDS_LOG2-1:0] reqIndex;
  logic [1:0]                 lane;
  logic                       isRead;
  logic                       tagMatch;
  logic                       hit;

  assign reqTag   = busAddress[ADDRESS_WIDTH-1:LINE_WORDS_LOG2+2];
  assign reqIndex = busAddress[LINE_WORDS_LOG2+1:2];
  assign lane     = busAddress[1:0];
  assign isRead   = busEnable & ~busWrite;
  assign tagMatch = (reqTag == lineTag);
  assign hit      = isRead & tagMatch & wordValid[reqIndex];

  // Big-endian lane select, zero-extended; size 11 behaves as a word.
  function automatic logic [31:0] extract(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  byteLane
  );
    logic [31:0] r;
    r = word;
    unique case (size)
      2'b00: begin
        unique case (byteLane)
          2'd0: r = {24'd0, word[31:24]};
          2'd1: r = {24'd0, word[23:16]};
          2'd2: r = {24'd0, word[15:8]};
          2'd3: r = {24'd0, word[7:0]};
        endcase
      end
      2'b01: r = byteLane[1] ? {16'd0, word[15:0]}
                             : {16'd0, word[31:16]};
      default: r = word;
    endcase
    return r;
  endfunction

  always_comb begin
    stateNext        = state;
    busWait          = busEnable;
    busReadData      = '0;
    romBusEnable     = 1'b0;
    romBusWrite      = 1'b0;
    romBusAccessSize = 2'b00;
    romBusAddress    = '0;
    romBusWriteData  = '0;
    unique case (state)
      Idle: begin
        if (hit) begin
          busWait     = 1'b0;
          busReadData = extract(lineData[reqIndex], busAccessSize, lane);
        end else if (busEnable) begin
          stateNext = busWrite ? Write : Fill;
        end
      end
      Fill: begin
        romBusEnable     = 1'b1;
        romBusAccessSize = 2'b10;
        romBusAddress    = {lineTag, fillIndex, 2'b00};
        if (hit) begin
          busWait     = 1'b0;
          busReadData = extract(lineData[reqIndex], busAccessSize, lane);
        end else if (isRead && tagMatch && reqIndex == fillIndex
                     && !romBusWait) begin
          busWait     = 1'b0;
          busReadData = extract(romBusReadData, busAccessSize, lane);
        end
        if (!romBusWait && fillIndex == LastIndex) stateNext = Idle;
      end
      Write: begin
        romBusEnable     = 1'b1;
        romBusWrite      = 1'b1;
        romBusAccessSize = busAccessSize;
        romBusAddress    = busAddress;
        romBusWriteData  = busWriteData;
        if (!romBusWait) begin
          busWait   = 1'b0;
          stateNext = Idle;
        end
      end
      default: stateNext = Idle;
    endcase
    // Reset quiets both bus sides within the same cycle.
    if (!reset) begin
      stateNext    = Idle;
      busWait      = 1'b0;
      busReadData  = '0;
      romBusEnable = 1'b0;
      romBusWrite  = 1'b0;
      romBusAccessSize = 2'b00;
      romBusAddress    = '0;
      romBusWriteData  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= Idle;
      lineTag      <= '0;
      wordValid    <= '0;
      fillIndex    <= '0;
      invalPending <= 1'b0;
    end else begin
      state <= stateNext;
      unique case (state)
        Idle: begin
          if (isRead && !hit) begin
            lineTag      <= reqTag;
            wordValid    <= '0;
            fillIndex    <= '0;
            invalPending <= 1'b0;
          end else if (invalidate) begin
            wordValid <= '0;
          end
        end
        Fill: begin
          if (invalidate) invalPending <= 1'b1;
          if (!romBusWait) begin
            fillIndex <= fillIndex + 1'b1;
            if (fillIndex == LastIndex && (invalPending || invalidate)) begin
              wordValid    <= '0;
              invalPending <= 1'b0;
            end else begin
              wordValid[fillIndex] <= 1'b1;
            end
          end
        end
        Write: begin
          if (invalidate || (!romBusWait && tagMatch)) wordValid <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (state == Fill && !romBusWait) lineData[fillIndex] <= romBusReadData;
  end

endmodule
